// File: rtl/ahbl_sram_if_v2_if.sv
// AHB-Lite slave-port bundle: master drives address/control/write data, slave returns
// ready, response and read data. Widths follow the bridge's data/address parameters.
interface ahbl_sram_if_v2_if #(
    parameter int AHB_DWIDTH = 32,
    parameter int AHB_AWIDTH = 20
);
    logic                  HSEL;
    logic [AHB_AWIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic                  HREADYIN;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [AHB_DWIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_sram_if_v2.sv
// AHB-Lite to single-port SRAM bridge: writes 1-cycle data phase, reads RD_LATENCY+1 cycles
// (HREADYOUT low while waiting). AHBL_SRAMIF_ERR_EN adds a two-cycle ERROR response.
module ahbl_sram_if_v2 #(
    parameter int AHB_DWIDTH      = 32,
    parameter int AHB_AWIDTH      = 20,
    parameter int MEM_DEPTH_BYTES = 65536,
    parameter int RD_LATENCY      = 1,
    localparam int NB  = AHB_DWIDTH / 8,
    localparam int BSH = $clog2(NB),
    localparam int MAW = AHB_AWIDTH - BSH
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    ahbl_sram_if_v2_if.slave        bus,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MAW-1:0]          mem_addr,
    output logic [NB-1:0]           mem_be,
    output logic [AHB_DWIDTH-1:0]   mem_wdata,
    input  logic [AHB_DWIDTH-1:0]   mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_WAIT
`ifdef AHBL_SRAMIF_ERR_EN
        , ST_ERR1
        , ST_ERR2
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [AHB_AWIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;

    logic                  accept;
    logic                  rd_last;
    logic [AHB_AWIDTH-1:0] addr_wrap;
    logic [MAW-1:0]        word_addr;
    logic [NB-1:0]         be;
    int                    lane_lo;
    int                    lane_n;
    logic                  unused_ok;

    assign accept    = bus.HSEL & bus.HREADYIN & bus.HTRANS[1] & bus.HREADYOUT;
    assign rd_last   = (state_q == ST_RD_WAIT) && (cnt_q == 3'(RD_LATENCY));
    assign addr_wrap = addr_q & AHB_AWIDTH'(MEM_DEPTH_BYTES - 1);
    assign word_addr = addr_wrap[AHB_AWIDTH-1:BSH];
    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};

`ifdef AHBL_SRAMIF_ERR_EN
    logic       illegal;
    logic [7:0] align_mask;

    always_comb begin
        align_mask = (8'd1 << bus.HSIZE) - 8'd1;
        illegal    = ({1'b0, bus.HADDR} >= (AHB_AWIDTH + 1)'(MEM_DEPTH_BYTES))
                  || (bus.HSIZE > 3'(BSH))
                  || ((8'(bus.HADDR[2:0]) & align_mask) != 8'd0);
    end
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // Accept is only possible when HREADYOUT is high, so a non-final read wait never sees it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        if (accept) begin
            addr_d  = bus.HADDR;
            size_d  = bus.HSIZE;
            cnt_d   = '0;
            state_d = bus.HWRITE ? ST_WR_DATA : ST_RD_WAIT;
`ifdef AHBL_SRAMIF_ERR_EN
            if (illegal) begin
                state_d = ST_ERR1;
            end
`endif
        end else begin
            case (state_q)
                ST_RD_WAIT: begin
                    if (rd_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
`ifdef AHBL_SRAMIF_ERR_EN
                ST_ERR1: state_d = ST_ERR2;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Oversize accesses use every lane; misaligned ones are truncated to the size boundary.
    always_comb begin
        lane_lo = 0;
        lane_n  = NB;
        be      = '0;
        if (size_q <= 3'(BSH)) begin
            lane_n  = 1 << size_q;
            lane_lo = int'(addr_q[BSH-1:0]) & ~(lane_n - 1);
        end
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= lane_lo) && (i < lane_lo + lane_n);
        end
    end

    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 2'b00;
        bus.HRDATA    = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        case (state_q)
            ST_WR_DATA: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_be    = be;
                mem_wdata = bus.HWDATA;
            end
            ST_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    mem_req  = 1'b1;
                    mem_addr = word_addr;
                end
                if (rd_last) begin
                    bus.HRDATA = mem_rdata;
                end else begin
                    bus.HREADYOUT = 1'b0;
                end
            end
`ifdef AHBL_SRAMIF_ERR_EN
            ST_ERR1: begin
                bus.HRESP     = 2'b01;
                bus.HREADYOUT = 1'b0;
            end
            ST_ERR2: begin
                bus.HRESP = 2'b01;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahbl_sram_if_v2.sv
// Bench for ahbl_sram_if_v2: directed plus randomized AHB traffic checked against a
// transaction-level memory model and a behavioural SRAM with RD_LATENCY return.
module tb_ahbl_sram_if_v2;
    localparam int DW    = 32;
    localparam int AW    = 20;
    localparam int DEPTH = 65536;
    localparam int L     = 2;
    localparam int NB    = DW / 8;
    localparam int MAW   = AW - 2;

    logic           HCLK = 1'b0;
    logic           HRESETN;
    logic           mem_req;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [NB-1:0]  mem_be;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    always #5 HCLK = ~HCLK;

    ahbl_sram_if_v2_if #(.AHB_DWIDTH(DW), .AHB_AWIDTH(AW)) bus ();

    ahbl_sram_if_v2 #(
        .AHB_DWIDTH(DW), .AHB_AWIDTH(AW), .MEM_DEPTH_BYTES(DEPTH), .RD_LATENCY(L)
    ) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef enum {PH_NONE, PH_WR, PH_RD, PH_ERR} ph_e;
    typedef struct packed {
        bit          sel;
        bit          rdyin;
        bit [1:0]    trans;
        bit          write;
        bit [31:0]   addr;
        bit [2:0]    size;
        bit [DW-1:0] wdata;
    } xfer_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [7:0]    refmem [DEPTH];
    logic [7:0]    sram [DEPTH];
    logic [DW-1:0] rd_dat [$];
    int            rd_due [$];
    xfer_t         dq [$];
    bit            rand_en = 1'b0;
    bit            was_rst = 1'b1;
    ph_e           ph = PH_NONE;
    int            ph_k = 0;
    int unsigned   ph_addr = 0;
    int unsigned   ph_size = 0;
    logic [DW-1:0] ph_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(int unsigned sz);
        return (sz > 2) ? NB : (32'd1 << sz);
    endfunction

    function automatic int unsigned first_byte(int unsigned a, int unsigned sz);
        int unsigned w = a % DEPTH;
        return w - (w % nbytes(sz));
    endfunction

    function automatic logic [NB-1:0] lanes(int unsigned a, int unsigned sz);
        logic [NB-1:0] m = '0;
        int unsigned b = first_byte(a, sz);
        for (int i = 0; i < int'(nbytes(sz)); i++) m[(b + i) % NB] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] ref_word(int unsigned a);
        logic [DW-1:0] w;
        int unsigned b = (a % DEPTH) / NB * NB;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = refmem[b + i];
        return w;
    endfunction

`ifdef AHBL_SRAMIF_ERR_EN
    function automatic bit is_illegal(int unsigned a, int unsigned sz);
        return (a >= DEPTH) || (sz > 2) || ((a % (32'd1 << sz)) != 0);
    endfunction
`endif

    function automatic xfer_t mk(bit wr, bit [31:0] a, bit [2:0] sz, bit [DW-1:0] d);
        xfer_t x;
        x.sel = 1'b1; x.rdyin = 1'b1; x.trans = 2'b10; x.write = wr;
        x.addr = a; x.size = sz; x.wdata = d;
        return x;
    endfunction

    function automatic xfer_t idle_xfer();
        return mk(1'b0, 32'd0, 3'd0, '0) & ~xfer_t'({1'b1, 1'b0, 2'b10, {(1+32+3+DW){1'b0}}});
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t       x;
        int unsigned r;
        x.sel   = ($urandom_range(0, 9) != 0);
        x.rdyin = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        x.trans = (r < 7) ? 2'(2 + (r & 1)) : 2'(r & 1);
        x.write = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        x.size = (r == 9) ? 3'd3 : 3'(r % 3);
        r = $urandom_range(0, 9);
        if (r < 5)      x.addr = $urandom_range(0, 63);
        else if (r < 7) x.addr = 32'h100 + $urandom_range(0, 15);
        else if (r < 9) x.addr = 32'h10000 + $urandom_range(0, 63);
        else            x.addr = $urandom_range(0, (1 << AW) - 1);
        if ($urandom_range(0, 9) < 7) x.addr = x.addr - (x.addr % nbytes(x.size));
        x.wdata = $urandom;
        return x;
    endfunction

    // One bus cycle: drive data-phase inputs, check outputs, update models, present next address.
    task automatic step();
        logic          exp_rdy, exp_req, exp_we;
        logic [1:0]    exp_resp;
        logic [NB-1:0] exp_be;
        logic [DW-1:0] exp_wdata, exp_rdata;
        bit            fin, acc;
        xfer_t         nx;
        int unsigned   b;

        if (rd_due.size() > 0 && rd_due[0] == cyc) begin
            mem_rdata = rd_dat.pop_front();
            void'(rd_due.pop_front());
        end else begin
            mem_rdata = $urandom;
        end
        bus.HWDATA = (ph == PH_WR) ? ph_wdata : DW'($urandom);
        #1;
        exp_rdy = 1'b1; exp_resp = 2'b00; exp_req = 1'b0; exp_we = 1'b0;
        exp_be = '0; exp_wdata = '0; exp_rdata = '0;
        case (ph)
            PH_WR: begin
                exp_req = 1'b1; exp_we = 1'b1;
                exp_be = lanes(ph_addr, ph_size); exp_wdata = ph_wdata;
            end
            PH_RD: begin
                exp_req = (ph_k == 0);
                if (ph_k < L) exp_rdy = 1'b0;
                else          exp_rdata = ref_word(ph_addr);
            end
            PH_ERR: begin
                exp_resp = 2'b01;
                exp_rdy = (ph_k != 0);
            end
            default: ;
        endcase
        chk("hreadyout", bus.HREADYOUT, exp_rdy);
        chk("hresp", bus.HRESP, exp_resp);
        chk("hrdata", bus.HRDATA, exp_rdata);
        chk("mem_req", mem_req, exp_req);
        chk("mem_be", mem_be, exp_be);
        chk("mem_wdata", mem_wdata, exp_wdata);
        if (exp_req || was_rst) chk("mem_we", mem_we, exp_we);
        if (exp_req) chk("mem_addr", mem_addr, (ph_addr % DEPTH) / NB);
        if (was_rst) chk("rst_mem_addr", mem_addr, 0);

        if (ph == PH_WR) begin
            b = first_byte(ph_addr, ph_size);
            for (int i = 0; i < int'(nbytes(ph_size)); i++)
                refmem[b + i] = ph_wdata[8*((b + i) % NB) +: 8];
        end
        if (mem_req === 1'b1) begin
            b = (int'(mem_addr) * NB) % DEPTH;
            if (mem_we === 1'b1) begin
                for (int i = 0; i < NB; i++) if (mem_be[i]) sram[b + i] = mem_wdata[8*i +: 8];
            end else begin
                rd_dat.push_back({sram[b + 3], sram[b + 2], sram[b + 1], sram[b]});
                rd_due.push_back(cyc + L);
            end
        end

        fin = (ph == PH_NONE) || (ph == PH_WR) || (ph == PH_RD && ph_k == L)
           || (ph == PH_ERR && ph_k == 1);
        if (fin && dq.size() > 0) nx = dq.pop_front();
        else if (!fin || rand_en) nx = rand_xfer();
        else nx = idle_xfer();
        if (!fin) nx.rdyin = 1'($urandom_range(0, 1));
        bus.HSEL = nx.sel; bus.HREADYIN = nx.rdyin; bus.HTRANS = nx.trans;
        bus.HWRITE = nx.write; bus.HADDR = AW'(nx.addr); bus.HSIZE = nx.size;
        bus.HBURST = 3'($urandom_range(0, 7));
        acc = fin && nx.sel && nx.rdyin && nx.trans[1];

        if (!HRESETN) begin
            ph = PH_NONE; ph_k = 0;
        end else if (fin) begin
            ph_k = 0;
            if (acc) begin
                ph_addr = nx.addr; ph_size = nx.size; ph_wdata = nx.wdata;
                ph = nx.write ? PH_WR : PH_RD;
`ifdef AHBL_SRAMIF_ERR_EN
                if (is_illegal(nx.addr, nx.size)) ph = PH_ERR;
`endif
            end else begin
                ph = PH_NONE;
            end
        end else begin
            ph_k++;
        end
        was_rst = !HRESETN;
        cyc++;
        @(negedge HCLK);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            refmem[i] = 8'($urandom);
            sram[i] = refmem[i];
        end
        HRESETN = 1'b0;
        mem_rdata = '0;
        bus.HSEL = 1'b0; bus.HREADYIN = 1'b1; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HADDR = '0; bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HWDATA = '0;
        @(negedge HCLK);
        repeat (3) step();
        HRESETN = 1'b1;

        dq.push_back(mk(1'b1, 32'h100, 3'd2, 32'hDEADBEEF));
        dq.push_back(mk(1'b1, 32'h103, 3'd0, 32'hAA000000));
        dq.push_back(mk(1'b1, 32'h102, 3'd1, 32'hBBCC0000));
        dq.push_back(mk(1'b0, 32'h100, 3'd2, '0));
        dq.push_back(mk(1'b1, 32'h10, 3'd2, 32'h0BADF00D));
        dq.push_back(mk(1'b0, 32'h10, 3'd2, '0));
        dq.push_back(mk(1'b0, 32'h10000, 3'd2, '0));
        dq.push_back(mk(1'b1, 32'h21, 3'd1, 32'h13572468));
        dq.push_back(mk(1'b0, 32'h20, 3'd7, '0));
        repeat (30) step();

        rand_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        n = 0;
        while (ph != PH_NONE && n < 10) begin step(); n++; end

        dq.push_back(mk(1'b0, 32'h20, 3'd2, '0));
        n = 0;
        while (!(ph == PH_RD && ph_k == 1) && n < 20) begin step(); n++; end
        chk("rst_reach_rd_wait", 64'(ph == PH_RD && ph_k == 1), 64'd1);
        HRESETN = 1'b0;
        step();
        HRESETN = 1'b1;
        step();
        dq.push_back(mk(1'b0, 32'h20, 3'd2, '0));
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_if_v2.md
Name: ahbl_sram_if_v2

Overview:
Parametrised AHB-Lite slave that bridges the system bus to a single-port synchronous SRAM with configurable read latency. It replaces the fixed 32-bit, request/ack interface with these features:
- Data width is set by parameter; memory depth and read latency are set by parameter.
- Byte-lane write strobes are generated from HSIZE and HADDR.
- Writes complete with zero wait states; reads use a latency-matched wait.
- An optional ERROR response covers illegal accesses.
The block sits between the AHB-Lite matrix slave port and the SRAM macro wrapper.

Parameters:
AHB_DWIDTH, 32, bus and memory data width; legal values 32 or 64.
AHB_AWIDTH, 20, HADDR width in bits.
MEM_DEPTH_BYTES, 65536, implemented memory size in bytes; must be a power of 2 and no larger than 2^AHB_AWIDTH.
RD_LATENCY, 1, cycles from mem_req to valid mem_rdata; legal range 1..4.

Ports:
HCLK  in  1  bus clock; all logic is on the rising edge.
HRESETN  in  1  reset, synchronous, active-low.
HSEL  in  1  slave select.
HADDR  in  AHB_AWIDTH  byte address.
HTRANS  in  2  transfer type (IDLE, BUSY, NONSEQ, SEQ).
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size.
HBURST  in  3  burst type; accepted but ignored, because every beat carries its own address.
HWDATA  in  AHB_DWIDTH  write data.
HREADYIN  in  1  bus ready.
HREADYOUT  out  1  slave ready.
HRESP  out  2  00 = OKAY, 01 = ERROR.
HRDATA  out  AHB_DWIDTH  read data.
mem_req  out  1  single-cycle memory access strobe.
mem_we  out  1  write enable; valid only with mem_req.
mem_addr  out  AHB_AWIDTH-log2(AHB_DWIDTH/8)  word address.
mem_be  out  AHB_DWIDTH/8  byte-lane enables.
mem_wdata  out  AHB_DWIDTH  write data to memory.
mem_rdata  in  AHB_DWIDTH  memory read data, valid exactly RD_LATENCY cycles after mem_req.

Behaviour:
- Reset: clock is HCLK; reset is synchronous, active-low HRESETN. While HRESETN=0 at a rising edge:
  - state returns to IDLE and the latency counter is cleared;
  - HREADYOUT=1, HRESP=00, HRDATA=0;
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset mid-transfer: the transfer is abandoned and no mem_req is issued afterwards.
- Accept condition: HSEL & HREADYIN & HTRANS[1] & HREADYOUT. On accept, latch HADDR, HWRITE and HSIZE.
- IDLE/BUSY transfers: OKAY response, zero wait, no memory access.
- States: IDLE, WR_DATA, RD_WAIT, ERR1, ERR2.
- IDLE → WR_DATA on an accepted write; IDLE → RD_WAIT on an accepted read.
- WR_DATA (one cycle, HREADYOUT=1):
  - drives mem_req=1, mem_we=1, mem_addr = latched address >> log2(DW/8), mem_wdata = HWDATA;
  - mem_be is derived from the latched HSIZE and the low address bits, with lanes little-endian.
  - A new transfer accepted in the same cycle goes directly to WR_DATA or RD_WAIT; otherwise → IDLE.
- RD_WAIT (counter cnt runs 0..RD_LATENCY):
  - mem_req=1, mem_we=0, mem_be=0 only when cnt=0;
  - HREADYOUT=0 while cnt<RD_LATENCY;
  - when cnt=RD_LATENCY: HREADYOUT=1 and HRDATA=mem_rdata; a new transfer may be accepted, with the same transitions as WR_DATA.
- Read data phase length is RD_LATENCY+1 cycles. Write data phase length is 1 cycle.
- Back-to-back write then read: the write's mem_req and the read's mem_req fall in consecutive cycles, so there is never a port conflict.
- HRDATA is 0 outside the final read cycle.
- mem_wdata and mem_be are 0 whenever mem_we=0.
- HRESP is 00 in all states except ERR1/ERR2.

Optional Feature:
Macro: AHBL_SRAMIF_ERR_EN.
- Defined: an accepted transfer is illegal if HADDR ≥ MEM_DEPTH_BYTES, or HSIZE > log2(AHB_DWIDTH/8), or HADDR is not aligned to HSIZE.
  - An illegal transfer goes to ERR1 (HRESP=01, HREADYOUT=0), then ERR2 (HRESP=01, HREADYOUT=1), then IDLE.
  - No mem_req is issued for it. A transfer presented during ERR2 is accepted normally.
- Undefined: no ERR states exist and HRESP is constant 00.
  - Addresses wrap modulo MEM_DEPTH_BYTES.
  - Oversize HSIZE is treated as a full-width access (all mem_be set).
  - Misaligned addresses are truncated to HSIZE alignment.

Test Plan:
1. DW=32, write NONSEQ word to 0x100 with HWDATA 0xDEADBEEF → next cycle: mem_req=1, mem_we=1, mem_addr=0x40, mem_be=1111, mem_wdata=0xDEADBEEF, HREADYOUT=1.
2. Byte write to 0x103 with HWDATA 0xAA000000 → mem_be=1000, mem_addr=0x40. Halfword write to 0x102 → mem_be=1100.
3. RD_LATENCY=2, read 0x100 with memory returning 0x12345678 → mem_req high 1 cycle, HREADYOUT low 2 cycles, then HREADYOUT=1 and HRDATA=0x12345678 in the 3rd cycle.
4. Write 0x10 immediately followed by read 0x10 → write mem_req in cycle N, read mem_req in cycle N+1, read returns the written data; no wait on the write.
5. Macro defined, MEM_DEPTH_BYTES=65536, read 0x10000 → ERR1/ERR2: HRESP=01 for 2 cycles, HREADYOUT 0 then 1, no mem_req. Macro undefined → mem_addr=0, HRESP=00.
6. HRESETN=0 during RD_WAIT with cnt=1 → the following cycle has HREADYOUT=1, mem_req=0, HRDATA=0, state IDLE; the next legal read completes normally.
